// File: rtl/serial_adder_4bit_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_4bit_pkg;

  localparam int unsigned ADD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(ADD_WIDTH);

endpackage

// File: rtl/serial_adder_4bit_if.sv
// Start/busy/done handshake bundle for serial_adder_4bit.
// With SERIAL_ADD_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_adder_4bit_if
  import serial_adder_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, A, B, input sum, cout, busy, done, ovf);
  modport slave  (input start, A, B, output sum, cout, busy, done, ovf);
`else
  modport master (output start, A, B, input sum, cout, busy, done);
  modport slave  (input start, A, B, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_adder_4bit_full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module full_adder (
  input  logic fA,
  input  logic fB,
  input  logic cIn,
  output logic fY,
  output logic cOut
);
  assign fY   = fA ^ fB ^ cIn;
  assign cOut = (fA & fB) | (cIn & (fA ^ fB));
endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial A+B, LSB first, through one full_adder behind a start/busy/done handshake.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow flag.
module serial_adder_4bit
  import serial_adder_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_4bit_if.slave  bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_y, fa_co;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .fA   (a_q[0]),
    .fB   (b_q[0]),
    .cIn  (carry_q),
    .fY   (fa_y),
    .cOut (fa_co)
  );

  // Partial result grows from the MSB down; on the last bit it is the full sum.
  assign res_next = {fa_y, res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_next[WIDTH-1:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_next;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final bit-cycle.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Self-checking bench for serial_adder_4bit against an arithmetic reference model.
module tb_serial_adder_4bit;
  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_4bit_if #(.WIDTH(W)) bus ();

  serial_adder_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ovf();
`ifdef SERIAL_ADD_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer addition plus signed-range test for overflow.
  function automatic void ref_add(input int a, input int b,
                                  output logic [3:0] s, output logic c, output logic o);
    int t, sa, sb;
    t  = a + b;
    s  = 4'(t % 16);
    c  = (t >= 16);
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    o  = ((sa + sb) > 7) || ((sa + sb) < -8);
  endfunction

  // Issue one start and wait (bounded) for done; lat is the cycle done appeared, -1 on timeout.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, output int lat,
                       output int busy_n, output logic [3:0] s, output logic c, output logic o);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    lat       = -1;
    busy_n    = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    s = bus.sum;
    c = bus.cout;
    o = get_ovf();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.sum !== 4'd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`ifdef SERIAL_ADD_OVF_EN
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
    rst_n = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    logic exp_busy, exp_done;
    logic [3:0] exp_sum;
    bus.A = 4'd3; bus.B = 4'd4; bus.start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      bus.start = 1'b0;
      exp_busy = (cyc >= 1 && cyc <= 4);
      exp_done = (cyc == 5);
      exp_sum  = (cyc >= 5) ? 4'd7 : 4'd0;
      total++; if (bus.busy !== exp_busy || bus.done !== exp_done || bus.sum !== exp_sum) begin
        bad++;
        $display("FAIL basic_cycle%0d busy=%b done=%b sum=%0d exp busy=%b done=%b sum=%0d",
                 cyc, bus.busy, bus.done, bus.sum, exp_busy, exp_done, exp_sum);
      end
    end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_wrap();
    int a_t[3] = '{15, 7, 8};
    int b_t[3] = '{1, 1, 8};
    int lat, bn;
    logic [3:0] s, es;
    logic c, o, ec, eo;
    for (int k = 0; k < 3; k++) begin
      do_op(4'(a_t[k]), 4'(b_t[k]), lat, bn, s, c, o);
      ref_add(a_t[k], b_t[k], es, ec, eo);
      total++; if (lat !== W + 1 || s !== es || c !== ec) begin
        bad++;
        $display("FAIL wrap_%0d_%0d lat=%0d sum=%0d cout=%b exp lat=%0d sum=%0d cout=%b",
                 a_t[k], b_t[k], lat, s, c, W + 1, es, ec);
      end
`ifdef SERIAL_ADD_OVF_EN
      total++; if (o !== eo) begin bad++; $display("FAIL wrap_ovf_%0d_%0d got=%b exp=%b", a_t[k], b_t[k], o, eo); end
`endif
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.A = 4'd2; bus.B = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.A = 4'd9; bus.B = 4'd9; bus.start = 1'b1;
    lat = -1;
    for (int cyc = 3; cyc <= 12; cyc++) begin
      tick();
      bus.start = 1'b0;
      if (bus.done) begin
        lat = cyc;
        break;
      end
    end
    total++; if (lat !== 5 || bus.sum !== 4'd5 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start lat=%0d sum=%0d cout=%b exp lat=5 sum=5 cout=0", lat, bus.sum, bus.cout);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.A = 4'd6; bus.B = 4'd5; bus.start = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      bus.start = 1'b0;
      if (cyc == 1) begin
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL b2b_accept done=%b busy=%b exp done=0 busy=1", bus.done, bus.busy);
        end
      end
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (cyc == 3) begin
        total++; if (bus.sum !== 4'd5) begin bad++; $display("FAIL b2b_held_sum got=%0d exp=5", bus.sum); end
      end
    end
    total++; if (lat !== 5 || bus.sum !== 4'd11 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result lat=%0d sum=%0d cout=%b exp lat=5 sum=11 cout=0", lat, bus.sum, bus.cout);
    end
  endtask

  task automatic test_reset_mid();
    bool_loop: begin end
    tick();
    bus.A = 4'd5; bus.B = 4'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 4'd0 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b sum=%0d cout=%b exp all 0", bus.busy, bus.done, bus.sum, bus.cout);
    end
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL reset_mid_no_done cycle%0d done=%b busy=%b exp 0/0", cyc, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    int lat, bn, a, b;
    logic [3:0] s, es;
    logic c, o, ec, eo;
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      do_op(4'(a), 4'(b), lat, bn, s, c, o);
      ref_add(a, b, es, ec, eo);
      total++; if (lat !== W + 1 || bn !== W || s !== es || c !== ec) begin
        bad++;
        $display("FAIL rand_%0d_plus_%0d lat=%0d busy_cycles=%0d sum=%0d cout=%b exp lat=%0d busy_cycles=%0d sum=%0d cout=%b",
                 a, b, lat, bn, s, c, W + 1, W, es, ec);
      end
`ifdef SERIAL_ADD_OVF_EN
      total++; if (o !== eo) begin bad++; $display("FAIL rand_ovf_%0d_plus_%0d got=%b exp=%b", a, b, o, eo); end
`endif
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
